// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for an N-stage back end.
// Tracks in-flight destinations, inserts load-use bubbles, freezes on
// memory wait and optionally squashes the IF/ID slot after a taken branch.
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   ena, ext_stall      global enable, memory wait freeze
//   id_*                decoded ID-stage instruction fields
//   pc_we, if_id_ena    front-end write enables
//   if_id_flush         load a bubble into IF/ID
//   stage_ena           per back-end stage register enable
//   stage_valid         scoreboard valid bits (index 0 = EXE)
//   id_stall            hazard stall this cycle
//   stall_cnt           saturating count of hazard stall cycles
module pipe_hazard_ctrl #(
   parameter int STAGES           = 3,
   parameter int REG_ADDR_W       = 5,
   parameter int LOAD_READY_STAGE = 2,
   parameter int FLUSH_SLOTS      = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ena,
   input  logic                  ext_stall,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic                  id_rs_used,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic                  id_rt_used,
   input  logic                  id_we,
   input  logic [REG_ADDR_W-1:0] id_waddr,
   input  logic                  id_is_load,
   input  logic                  id_branch_taken,
   output logic                  pc_we,
   output logic                  if_id_ena,
   output logic                  if_id_flush,
   output logic [STAGES-1:0]     stage_ena,
   output logic [STAGES-1:0]     stage_valid,
   output logic                  id_stall,
   output logic [15:0]           stall_cnt
);

   // Loads are unforwardable only while younger than this stage index.
   localparam int LRS = (LOAD_READY_STAGE > STAGES) ? STAGES
                                                    : LOAD_READY_STAGE;
   localparam logic FLUSH_EN = (FLUSH_SLOTS == 1);

   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic [REG_ADDR_W-1:0] waddr;
      logic                  is_load;
   } entry_t;

   entry_t sb [STAGES];
   entry_t new_e;
   logic   rs_hit;
   logic   rt_hit;
   logic   hazard;
   logic   adv;

   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      for (int k = 0; k < LRS; k++) begin
         if (sb[k].valid && sb[k].we && sb[k].is_load) begin
            if (sb[k].waddr == id_rs_addr) rs_hit = 1'b1;
            if (sb[k].waddr == id_rt_addr) rt_hit = 1'b1;
         end
      end
   end

   // Register 0 is hard-wired, so it can never carry a dependency.
   assign hazard = ~reset & id_valid &
                   ((id_rs_used & (id_rs_addr != '0) & rs_hit) |
                    (id_rt_used & (id_rt_addr != '0) & rt_hit));

   assign adv         = ena & ~ext_stall & ~reset;
   assign id_stall    = adv & hazard;
   assign pc_we       = adv & ~hazard;
   assign if_id_ena   = adv & ~hazard;
   assign stage_ena   = {STAGES{adv}};
   assign if_id_flush = FLUSH_EN & adv & ~hazard &
                        id_valid & id_branch_taken;

   always_comb begin
      stage_valid = '0;
      for (int k = 0; k < STAGES; k++) begin
         stage_valid[k] = sb[k].valid & ~reset;
      end
   end

   // A stalled instruction enters EXE as a bubble while ID holds it.
   always_comb begin
      new_e         = '0;
      new_e.valid   = id_valid & ~hazard;
      new_e.we      = id_we;
      new_e.waddr   = id_waddr;
      new_e.is_load = id_is_load;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            sb[k] <= '0;
         end
         stall_cnt <= '0;
      end else if (adv) begin
         sb[0] <= new_e;
         for (int k = 1; k < STAGES; k++) begin
            sb[k] <= sb[k-1];
         end
         if (hazard && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the fixed two-stage pipeline controller: per-stage enables for an N-stage back end (EXE..WB) instead of a hard-wired IF/ID + ID/EXE pair.
- Holds a destination-register scoreboard for in-flight instructions and detects RAW hazards that bypassing cannot resolve, such as load-use before the data is ready.
- Inserts bubbles, freezes on external memory wait, and optionally squashes the instruction behind a taken branch.
- Sits between ID decode and the PC/IF_ID/stage registers of the core.

Parameters:
- STAGES, 3, number of back-end stages after ID (index 0 = EXE); legal 1..8.
- REG_ADDR_W, 5, GPR address width.
- LOAD_READY_STAGE, 2, first stage index whose load result is forwardable; legal 1..STAGES.
- FLUSH_SLOTS, 0, 0 = delay-slot semantics (no squash); 1 = squash the IF/ID instruction on a taken branch.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ena  in  1  global core enable; 0 freezes everything
- ext_stall  in  1  memory wait; freezes all stages while 1
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  REG_ADDR_W  source 1 address
- id_rs_used  in  1  source 1 is read
- id_rt_addr  in  REG_ADDR_W  source 2 address
- id_rt_used  in  1  source 2 is read
- id_we  in  1  ID instruction writes a GPR
- id_waddr  in  REG_ADDR_W  its destination
- id_is_load  in  1  ID instruction is a load
- id_branch_taken  in  1  ID branch resolved taken
- pc_we  out  1  PC write enable
- if_id_ena  out  1  IF/ID register enable
- if_id_flush  out  1  load a bubble into IF/ID
- stage_ena  out  STAGES  per-stage register enable
- stage_valid  out  STAGES  scoreboard valid bits
- id_stall  out  1  hazard stall this cycle
- stall_cnt  out  16  count of hazard stall cycles

Behaviour:
- Scoreboard entry k holds {valid, we, waddr, is_load}.
- Reset (registered, sync): all entries cleared, stall_cnt=0. While reset=1 all combinational outputs are forced to 0.
- Hazard, combinational: id_valid AND, for rs or rt, used AND addr!=0 AND some k < LOAD_READY_STAGE has valid & we & is_load & waddr==addr.
  - Non-load producers never cause a hazard; they are forwarded.
  - Register 0 never causes a hazard.
- adv = ena & ~ext_stall.
- id_stall = adv & hazard.
- pc_we = if_id_ena = adv & ~hazard.
- stage_ena[k] = adv for all k. When not advancing, the scoreboard holds.
- On adv, the scoreboard shifts: entry k+1 <= entry k; entry STAGES-1 retires.
- Entry 0 <= {id_valid & ~hazard, id_we, id_waddr, id_is_load}.
  - A hazard inserts a bubble in EXE while ID/IF hold.
  - The next cycle re-evaluates with the producer one stage older.
- if_id_flush = (FLUSH_SLOTS==1) & adv & ~hazard & id_valid & id_branch_taken.
  - A branch stalled on a hazard does not flush until it issues.
  - With FLUSH_SLOTS=0, if_id_flush is constantly 0.
- Stall count:
  - stall_cnt increments on id_stall.
  - It saturates at 16'hFFFF; no wrap.
  - It is frozen when ena=0 or ext_stall=1.
- Load-use penalty is exactly LOAD_READY_STAGE bubble cycles for a dependent instruction immediately following the load.
- Simultaneous ext_stall and hazard: the freeze wins; id_stall=0, no bubble is inserted, no count.
- Reset during a stall: the next cycle has an empty scoreboard; no hazard persists.
- stage_valid mirrors the entry valid bits.

Test Plan:
- Reset, then ena=1 with id_valid=1 non-load stream → pc_we=1 every cycle, stage_valid fills 001→011→111, stall_cnt=0.
- LOAD_READY_STAGE=2: lw $3 followed by add using rs=$3 → id_stall=1 for exactly 2 cycles, stage_valid[0]=0 in the bubble cycles, stall_cnt=2, then issue.
- Load writing $0 followed by a reader of $0 → no stall. Non-load writer of $5 then a reader of $5 → no stall.
- Hazard pending while ext_stall=1 for 3 cycles → all stage_ena=0, id_stall=0, stall_cnt unchanged, scoreboard unchanged. After release the hazard resumes normally.
- FLUSH_SLOTS=1, taken branch with no hazard → if_id_flush=1 for one cycle. Same branch with a load-use hazard → flush only in the issue cycle. FLUSH_SLOTS=0 → never flushes.
- Force stall_cnt to 16'hFFFE and create 3 hazard cycles → saturates at 16'hFFFF. Assert reset mid-stall → stall_cnt=0 and stage_valid=0 next cycle.
